// File: rtl/e_mdu_sched_pkg.sv
// Shared encodings, FSM state type and default latencies for the E-stage MDU
// issue controller.
package e_mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;
  localparam logic [2:0] MDU_NOP   = 3'b111;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // mult/multu/div/divu occupy the datapath; mthi/mtlo are single-cycle writes.
  function automatic logic is_arith(input logic [2:0] sel);
    return (sel[2] == 1'b0);
  endfunction

  function automatic logic is_div(input logic [2:0] sel);
    return (sel == MDU_DIV) || (sel == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_sched_if.sv
// E-stage <-> MDU controller bundle: issue handshake, D-stage hazard query and
// the datapath drive signals.
interface e_mdu_sched_if;
  logic        req;
  logic        op_valid;
  logic [2:0]  op_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_ready;
  logic        hilo_rd;
  logic        stall;
  logic        mdu_start;
  logic [2:0]  mdu_sel;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        busy;
  logic        done;
  logic        div0;

  modport master (
    output req, op_valid, op_sel, op_a, op_b, hilo_rd,
    input  op_ready, stall, mdu_start, mdu_sel, mdu_a, mdu_b, busy, done, div0
  );

  modport slave (
    input  req, op_valid, op_sel, op_a, op_b, hilo_rd,
    output op_ready, stall, mdu_start, mdu_sel, mdu_a, mdu_b, busy, done, div0
  );
endinterface

// File: rtl/e_mdu_sched_lat_cnt.sv
// Loadable 4-bit down-counter; nonzero means busy, a value of 1 flags the
// last busy cycle.
module e_mdu_lat_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_val,
  output logic       o_busy,
  output logic       o_last
);

  logic [3:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_busy = (r_cnt != 4'd0);
  assign o_last = (r_cnt == 4'd1);

endmodule

// File: rtl/e_mdu_sched.sv
// E-stage multiply/divide issue controller. Optional feature: define
// E_MDU_DIV0_EN to retire divide-by-zero as a one-cycle div0 event.
module e_mdu_sched
  import e_mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  e_mdu_sched_if.slave   bus
);

  mdu_state_e  r_state;
  logic        r_start;
  logic [2:0]  r_sel;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_div0;

  logic        w_ready;
  logic        w_accept;
  logic        w_arith;
  logic        w_div0;
  logic        w_load;
  logic [3:0]  w_lat;
  logic        w_busy;
  logic        w_last;

  assign w_ready  = (r_state == ST_IDLE);
  assign w_accept = bus.op_valid && w_ready && !bus.req && (bus.op_sel <= MDU_MTLO);
  assign w_arith  = is_arith(bus.op_sel);

`ifdef E_MDU_DIV0_EN
  assign w_div0 = is_div(bus.op_sel) && (bus.op_b == 32'd0);
`else
  assign w_div0 = 1'b0;
`endif

  assign w_lat  = is_div(bus.op_sel) ? 4'(DIV_LAT) : 4'(MUL_LAT);
  assign w_load = w_accept && w_arith && !w_div0;

  e_mdu_lat_cnt u_lat_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_val  (w_lat),
    .o_busy (w_busy),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_start <= 1'b0;
      r_sel   <= MDU_NOP;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_div0  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_sel   <= MDU_NOP;
      r_div0  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a <= bus.op_a;
            r_b <= bus.op_b;
            if (w_div0) begin
              // Zero divisor retires immediately; HI/LO stay untouched.
              r_div0 <= 1'b1;
            end else if (w_arith) begin
              r_sel   <= bus.op_sel;
              r_start <= 1'b1;
              r_state <= ST_RUN;
            end else begin
              r_sel <= bus.op_sel;
            end
          end
        end
        ST_RUN: begin
          if (w_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.op_ready  = w_ready;
  assign bus.mdu_start = r_start;
  assign bus.mdu_sel   = r_sel;
  assign bus.mdu_a     = r_a;
  assign bus.mdu_b     = r_b;
  assign bus.busy      = w_busy;
  assign bus.done      = w_last || r_div0;
  assign bus.div0      = r_div0;
  assign bus.stall     = bus.hilo_rd &&
                         (w_busy || (bus.op_valid && !bus.req && is_arith(bus.op_sel)));

endmodule

// File: tb/tb_e_mdu_sched.sv
// Directed self-checking bench for e_mdu_sched with default latencies
// (MUL_LAT=5, DIV_LAT=10); expectations follow E_MDU_DIV0_EN when defined.
module tb_e_mdu_sched;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  e_mdu_sched_if bus ();

  e_mdu_sched #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic hr);
    bus.op_valid = v;
    bus.req      = r;
    bus.op_sel   = sel;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.hilo_rd  = hr;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b111, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.op_ready), 32'd1);
    check("rst_sel",   32'(bus.mdu_sel),  32'd7);
    check("rst_busy",  32'(bus.busy),     32'd0);
    check("rst_start", 32'(bus.mdu_start), 32'd0);
    check("rst_done",  32'(bus.done),     32'd0);
    check("rst_div0",  32'(bus.div0),     32'd0);
    check("rst_a",     bus.mdu_a,         32'd0);
    @(negedge clk) reset = 1'b0;
    step();

    // mult with an mfhi waiting in D from the accept cycle on
    drive(1'b1, 1'b0, 3'b000, 32'hFFFF_FFFE, 32'd3, 1'b1);
    check("mult_stall_t", 32'(bus.stall), 32'd1);
    check("mult_ready_t", 32'(bus.op_ready), 32'd1);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      check("mult_start", 32'(bus.mdu_start), 32'(k == 1));
      check("mult_busy",  32'(bus.busy),      32'd1);
      check("mult_done",  32'(bus.done),      32'(k == 5));
      check("mult_ready", 32'(bus.op_ready),  32'd0);
      check("mult_stall", 32'(bus.stall),     32'd1);
      if (k == 1) begin
        check("mult_sel", 32'(bus.mdu_sel), 32'd0);
        check("mult_a",   bus.mdu_a,        32'hFFFF_FFFE);
        check("mult_b",   bus.mdu_b,        32'd3);
      end else begin
        check("mult_sel_nop", 32'(bus.mdu_sel), 32'd7);
      end
      step();
    end
    check("mult_end_busy",  32'(bus.busy),     32'd0);
    check("mult_end_ready", 32'(bus.op_ready), 32'd1);
    check("mult_end_stall", 32'(bus.stall),    32'd0);
    check("mult_end_done",  32'(bus.done),     32'd0);

    // reset asserted two cycles into a multu
    drive(1'b1, 1'b0, 3'b001, 32'd7, 32'd9, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("rmid_start_t1", 32'(bus.mdu_start), 32'd1);
    step();
    check("rmid_busy_t2", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rmid_busy",  32'(bus.busy),      32'd0);
    check("rmid_ready", 32'(bus.op_ready),  32'd1);
    check("rmid_start", 32'(bus.mdu_start), 32'd0);
    check("rmid_sel",   32'(bus.mdu_sel),   32'd7);
    check("rmid_a",     bus.mdu_a,          32'd0);
    @(negedge clk) reset = 1'b0;
    step();

    // req blocks a div, then the same div issues
    drive(1'b1, 1'b1, 3'b010, 32'd100, 32'd7, 1'b1);
    check("req_stall", 32'(bus.stall), 32'd0);
    step();
    check("req_busy",  32'(bus.busy),      32'd0);
    check("req_start", 32'(bus.mdu_start), 32'd0);
    check("req_sel",   32'(bus.mdu_sel),   32'd7);
    drive(1'b1, 1'b0, 3'b010, 32'd100, 32'd7, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("div_start", 32'(bus.mdu_start), 32'd1);
    check("div_sel",   32'(bus.mdu_sel),   32'd2);
    for (int k = 1; k <= 10; k++) begin
      check("div_busy", 32'(bus.busy), 32'd1);
      check("div_done", 32'(bus.done), 32'(k == 10));
      step();
    end
    check("div_end_busy", 32'(bus.busy), 32'd0);

    // divu with hilo_rd held high, then mthi/mtlo back to back
    drive(1'b1, 1'b0, 3'b011, 32'd50, 32'd5, 1'b1);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      check("divu_stall", 32'(bus.stall), 32'd1);
      step();
    end
    check("divu_stall_end", 32'(bus.stall), 32'd0);
    drive(1'b1, 1'b0, 3'b100, 32'hDEAD_BEEF, 32'd0, 1'b1);
    check("mthi_stall", 32'(bus.stall), 32'd0);
    step();
    drive(1'b1, 1'b0, 3'b101, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi_sel",   32'(bus.mdu_sel),   32'd4);
    check("mthi_a",     bus.mdu_a,          32'hDEAD_BEEF);
    check("mthi_start", 32'(bus.mdu_start), 32'd0);
    check("mthi_busy",  32'(bus.busy),      32'd0);
    check("mthi_ready", 32'(bus.op_ready),  32'd1);
    step();
    drive(1'b1, 1'b0, 3'b110, 32'd1, 32'd1, 1'b1);
    check("mtlo_sel",    32'(bus.mdu_sel), 32'd5);
    check("mtlo_a",      bus.mdu_a,        32'h1234_5678);
    check("illeg_stall", 32'(bus.stall),   32'd0);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    check("illeg_sel",   32'(bus.mdu_sel),   32'd7);
    check("illeg_busy",  32'(bus.busy),      32'd0);
    check("illeg_start", 32'(bus.mdu_start), 32'd0);
    check("illeg_a",     bus.mdu_a,          32'h1234_5678);

    // divide by zero
    drive(1'b1, 1'b0, 3'b010, 32'd9, 32'd0, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
`ifdef E_MDU_DIV0_EN
    check("dz_div0",  32'(bus.div0),      32'd1);
    check("dz_done",  32'(bus.done),      32'd1);
    check("dz_start", 32'(bus.mdu_start), 32'd0);
    check("dz_busy",  32'(bus.busy),      32'd0);
    check("dz_ready", 32'(bus.op_ready),  32'd1);
    check("dz_sel",   32'(bus.mdu_sel),   32'd7);
    step();
    check("dz_div0_end", 32'(bus.div0), 32'd0);
    check("dz_done_end", 32'(bus.done), 32'd0);
`else
    check("dz_start", 32'(bus.mdu_start), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      check("dz_busy", 32'(bus.busy), 32'd1);
      check("dz_div0", 32'(bus.div0), 32'd0);
      check("dz_done", 32'(bus.done), 32'(k == 10));
      step();
    end
    check("dz_end_busy", 32'(bus.busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/e_mdu_sched.md
# e_mdu_sched

Issue and sequencing controller for the E-stage multiply/divide unit. It accepts MDU operations from the E stage with a valid/ready handshake and blocks issue while an interrupt request is pending. It drives the MDU's start, function-select and operand inputs, and counts the fixed operation latency. It also generates the pipeline stall for D-stage instructions that touch HI/LO while an operation is in flight.

## Interface
Parameters:
- MUL_LAT, default 5: busy cycles for mult/multu (2..15).
- DIV_LAT, default 10: busy cycles for div/divu (2..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock domain.
- req  in  1  interrupt/exception taken in E this cycle; blocks issue.
- op_valid  in  1  E-stage instruction is an MDU op.
- op_sel  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 illegal.
- op_a, op_b  in  32  rs/rt operand values.
- op_ready  out  1  controller can accept an op this cycle.
- hilo_rd  in  1  D-stage instruction is mfhi/mflo or an MDU op.
- stall  out  1  freeze F/D, bubble into E.
- mdu_start  out  1  one-cycle start pulse to the MDU datapath.
- mdu_sel  out  3  registered function select to the MDU.
- mdu_a, mdu_b  out  32  registered operands to the MDU.
- busy  out  1  arithmetic operation in flight.
- done  out  1  one-cycle pulse in the last busy cycle.
- div0  out  1  pulse: divide by zero was detected (see Configuration).

## Operation
- States: IDLE, RUN.
- Accept condition: `op_valid && op_ready && !req && op_sel <= 101`.
- op_ready is high only in IDLE.
- Arithmetic accept (000–011) in IDLE:
  - Register op_sel, op_a and op_b into mdu_sel/a/b.
  - Set mdu_start for the next cycle.
  - Load the counter with MUL_LAT (000/001) or DIV_LAT (010/011).
  - Go to RUN.
- mthi/mtlo accept:
  - Register mdu_sel/a for exactly one cycle with mdu_start=0; the MDU writes HI/LO on that select.
  - Stay in IDLE; busy stays 0.
- In cycles without an accept, mdu_sel is 111 (no-op).
- RUN:
  - Counter decrements each cycle.
  - When counter==1: assert done, return to IDLE.
- req asserted during RUN does not abort the operation. req only suppresses acceptance in the cycle it is high.
- op_valid while not ready, or an illegal op_sel, is ignored. No state change; the requester holds.
- stall (combinational) = `hilo_rd && (busy || (op_valid && !req && op_sel <= 011))`.
- Reset (asynchronous, any time, including mid-RUN): state IDLE, counter 0. All outputs 0 except op_ready=1 and mdu_sel=111.

## Timing
- Arithmetic accept at edge t (sampled in cycle t):
  - mdu_start=1 only in cycle t+1.
  - busy=1 in cycles t+1..t+LAT.
  - done=1 in cycle t+LAT.
  - op_ready=0 in cycles t+1..t+LAT.
  - Earliest next accept is cycle t+LAT+1.
- mthi/mtlo accepted in cycle t: mdu_sel valid in cycle t+1 only. The next op can be accepted in cycle t+1.
- An mfhi in D during the accept cycle of a mult is stalled from cycle t. It is released in cycle t+LAT+1.
- Counter width is 4 bits. The counter never wraps, because LAT is at least 2.

## Configuration
- Macro `E_MDU_DIV0_EN`, defined:
  - div/divu with op_b==0 is accepted as a one-cycle event.
  - mdu_start stays 0; HI/LO are untouched.
  - div0 pulses in cycle t+1; done also pulses in cycle t+1; busy stays 0.
- Not defined: divide by zero follows the normal DIV_LAT sequence, and div0 is tied 0.

## Structure
- Package e_mdu_pkg holds:
  - op_sel encodings (MDU_MULT … MDU_MTLO, MDU_NOP=111);
  - the state enum;
  - the default latencies.
- Sub-module e_mdu_lat_cnt: a loadable 4-bit down-counter with a last-cycle flag, reused for done and busy.

## Test plan
- Reset mid-op: mult accepted, reset asserted in cycle t+2 → immediately busy=0, op_ready=1, mdu_start=0, mdu_sel=111.
- mult, A=0xFFFFFFFE, B=3, LAT 5 → mdu_start at t+1, busy at t+1..t+5, done at t+5, op_ready back at t+6.
- req=1 with op_valid=1 and op_sel=010 → no accept, no start, stall=0. Same op with req=0 next cycle → accepted, busy for 10 cycles.
- divu in RUN, hilo_rd=1 → stall high every busy cycle, low at t+11. mthi issued in IDLE → mdu_sel=100 for one cycle, busy stays 0.
- With E_MDU_DIV0_EN: div with B=0 → div0 and done at t+1, no mdu_start. Without the macro: the same op runs the full 10 busy cycles and div0 stays 0.
